// File: rtl/prime_check.sv
// Trial-division primality tester driving an external iterative divider.
// Trivial candidates (<4) resolve in one cycle; otherwise one ISSUE cycle plus the divider wait per trial.
// go is ignored while busy; ISSUE stalls until the divider reports ready.
module prime_check #(
  parameter int WIDTH_LOG = 4,
  parameter int WIDTH     = 1 << WIDTH_LOG,
  parameter int HI        = WIDTH - 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic [HI:0] num,
  output logic        ready,
  output logic        is_prime,
  output logic [HI:0] factor,
  output logic        error,
  output logic        div_go,
  output logic [HI:0] div_num,
  output logic [HI:0] div_den,
  input  logic        div_ready,
  input  logic        div_error,
  input  logic [HI:0] div_quot,
  input  logic [HI:0] div_rem
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [HI:0] C_TWO   = WIDTH'(2);
  localparam logic [HI:0] C_THREE = WIDTH'(3);
  localparam logic [HI:0] C_FOUR  = WIDTH'(4);

  state_t      r_state;
  logic        r_ready;
  logic        r_is_prime;
  logic [HI:0] r_factor;
  logic        r_error;
  logic        r_div_go;
  logic [HI:0] r_div_num;
  logic [HI:0] r_div_den;

  state_t      w_state_nxt;
  logic        w_ready_nxt;
  logic        w_is_prime_nxt;
  logic [HI:0] w_factor_nxt;
  logic        w_error_nxt;
  logic        w_div_go_nxt;
  logic [HI:0] w_div_num_nxt;
  logic [HI:0] w_div_den_nxt;

  // State register; reset abandons any test in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-output logic. div_num doubles as the captured candidate.
  always_comb begin
    w_state_nxt    = r_state;
    w_ready_nxt    = r_ready;
    w_is_prime_nxt = r_is_prime;
    w_factor_nxt   = r_factor;
    w_error_nxt    = r_error;
    w_div_go_nxt   = 1'b0;
    w_div_num_nxt  = r_div_num;
    w_div_den_nxt  = r_div_den;
    unique case (r_state)
      S_IDLE: begin
        if (go) begin
          w_error_nxt = 1'b0;
          if (num < C_TWO) begin
            w_is_prime_nxt = 1'b0;
            w_factor_nxt   = '0;
          end else if (num < C_FOUR) begin
            w_is_prime_nxt = 1'b1;
            w_factor_nxt   = num;
          end else begin
            w_div_num_nxt = num;
            w_div_den_nxt = C_TWO;
            w_ready_nxt   = 1'b0;
            w_state_nxt   = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (div_ready) begin
          w_div_go_nxt = 1'b1;
          w_state_nxt  = S_WAIT;
        end
      end
      S_WAIT: begin
        // While our start pulse is still on the wire the divider has not
        // sampled it yet, so its ready flag belongs to the previous trial.
        if (div_ready && !r_div_go) begin
          if (div_error) begin
            w_error_nxt    = 1'b1;
            w_is_prime_nxt = 1'b0;
            w_factor_nxt   = '0;
            w_ready_nxt    = 1'b1;
            w_state_nxt    = S_IDLE;
          end else if (div_rem == '0) begin
            w_is_prime_nxt = 1'b0;
            w_factor_nxt   = r_div_den;
            w_ready_nxt    = 1'b1;
            w_state_nxt    = S_IDLE;
          end else if (div_quot < r_div_den) begin
            // quotient < divisor implies divisor^2 > candidate
            w_is_prime_nxt = 1'b1;
            w_factor_nxt   = r_div_num;
            w_ready_nxt    = 1'b1;
            w_state_nxt    = S_IDLE;
          end else begin
            w_div_den_nxt = (r_div_den == C_TWO) ? C_THREE : (r_div_den + C_TWO);
            w_state_nxt   = S_ISSUE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ready_nxt = 1'b1;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready    <= 1'b1;
      r_is_prime <= 1'b0;
      r_factor   <= '0;
      r_error    <= 1'b0;
      r_div_go   <= 1'b0;
      r_div_num  <= '0;
      r_div_den  <= '0;
    end else begin
      r_ready    <= w_ready_nxt;
      r_is_prime <= w_is_prime_nxt;
      r_factor   <= w_factor_nxt;
      r_error    <= w_error_nxt;
      r_div_go   <= w_div_go_nxt;
      r_div_num  <= w_div_num_nxt;
      r_div_den  <= w_div_den_nxt;
    end
  end

  assign ready    = r_ready;
  assign is_prime = r_is_prime;
  assign factor   = r_factor;
  assign error    = r_error;
  assign div_go   = r_div_go;
  assign div_num  = r_div_num;
  assign div_den  = r_div_den;

endmodule
